joy_nway: RTL and testbench
===========================

JOY_NWAY -- requirements
Module: joy_nway

Interface
REQ-001 SHALL have parameter PLAYERS, default 2, legal range 1..4; it sets the number of independent joystick channels.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, which is clk_sys at the emu level.
REQ-003 SHALL have port reset, input, 1 bit; asynchronous, active-high; clears all state.
REQ-004 SHALL have port socd_mode, input, 2 bits; opposing-direction resolution: 0 last-wins, 1 neutral, 2 first-wins, 3 passthrough.
REQ-005 SHALL have port restrict4, input, 1 bit; 1 = 4-way restriction (one axis only), 0 = 8-way.
REQ-006 SHALL have port indir, input, 4*PLAYERS bits; raw directions, player p at [4p+3:4p], bit order {U,D,L,R} (bit0 R), active-high, asynchronous to clk.
REQ-007 SHALL have port outdir, output, 4*PLAYERS bits; conditioned directions with the same packing as indir.
REQ-008 SHALL have port change, output, PLAYERS bits; one-cycle strobe per player when that player's outdir nibble changes.

Function
REQ-009 SHALL implement each player as an identical, independent channel; channels share only clk, reset, socd_mode and restrict4.
REQ-010 SHALL register each channel's input through two stages: in1 <= indir nibble, then in2 <= in1.
REQ-011 SHALL compute new presses as innew = in1 & ~in2, per bit.
REQ-012 SHALL hold a horizontal last-pressed register last_h (2 bits, {L,R}): innew R sets it to 01 and innew L sets it to 10; if both are new in the same cycle, L wins (10).
REQ-013 SHALL hold a vertical last-pressed register last_v (2 bits, {U,D}) with the same rules; if both are new in the same cycle, U wins.
REQ-014 SHALL resolve each axis using the look-ahead value of last_h/last_v (the value including this cycle's innew), so there is no one-cycle neutral glitch on a simultaneous press.
REQ-015 SHALL apply per-axis SOCD resolution: when one or neither direction is held, the output equals in1; when both are held, mode 0 outputs last_h/last_v, mode 1 outputs 00, mode 2 outputs the bitwise inverse of last_h/last_v (the earlier press), and mode 3 outputs 11.
REQ-016 SHALL hold a last-axis register last_ax (0 = horizontal, 1 = vertical): any new vertical press sets it to 1; a new horizontal press with no new vertical press in the same cycle sets it to 0.
REQ-017 SHALL, when restrict4 = 1 and both axes are non-zero after SOCD resolution, zero the axis not selected by the look-ahead value of last_ax.
REQ-018 SHALL, when restrict4 = 0, pass the SOCD result unchanged.
REQ-019 SHALL register outdir: an indir change before clock edge n is visible on outdir after edge n+1 (2-cycle latency).
REQ-020 SHALL register change[p] to 1 for exactly one cycle, one cycle after the outdir nibble of player p changes (3-cycle latency from indir).
REQ-021 SHALL apply socd_mode and restrict4 changes on the next edge with no state flush; last_* registers keep tracking in every mode, including passthrough.
REQ-022 SHALL leave last_h/last_v/last_ax unchanged on releases.
REQ-023 SHALL, on a release of the winning direction while the other is still held, output the still-held direction on the next registered cycle.
REQ-024 SHALL preserve a held last-wins state if a direction is re-pressed while its opposite is held; the new press updates last_h and the output follows it.

Reset
REQ-025 SHALL asynchronously clear in1, in2, last_h, last_v, last_ax, outdir and change to 0 while reset = 1.
REQ-026 SHALL release from reset with no spurious change strobe.
REQ-027 SHALL treat directions already held when reset is released as new presses; both-held ties resolve L and U per REQ-012/REQ-013, and the first non-zero outdir appears 2 edges after release.
REQ-028 SHALL return all outputs to 0 immediately, asynchronously, if reset asserts mid-operation.

Verification
REQ-029 SHALL verify last-wins: mode 0, restrict4 = 0, press R (0001), 5 cycles later add L (0011) -> outdir 0001 then 0010 two cycles after L; release L -> 0001; change pulses once per transition.
REQ-030 SHALL verify neutral and first-wins: with R then L held, mode 1 -> 0000; mode 2 -> 0001; mode 3 -> 0011; each mode switch takes effect one edge after socd_mode changes.
REQ-031 SHALL verify the simultaneous tie: indir goes 0000 -> 0011 in one cycle, mode 0 -> outdir 0010 at latency 2, never 0000 or 0011 in between; the same for 1100 -> 1000.
REQ-032 SHALL verify 4-way restriction: restrict4 = 1, hold R, then add U (1001) -> outdir 1000; then add L (1011) with mode 0 -> outdir 0010 (horizontal axis now selected).
REQ-033 SHALL verify channel independence and reset: PLAYERS = 4 with a different pattern per player -> no cross-talk; assert reset mid-hold -> outdir = 0 and change = 0 combinationally; deassert with 0011 held -> 0010 after 2 edges.

Source files
------------

// File: rtl/joy_nway.sv
// joy_nway: N-player joystick direction conditioner.
//
// Each player channel synchronises its raw direction nibble, resolves opposing
// directions (SOCD), optionally restricts to one axis (4-way), and registers
// the result. A per-player strobe marks each change of the conditioned nibble.
//
// Ports
//   clk        system clock (clk_sys)
//   reset      asynchronous, active-high; clears all state
//   socd_mode  0 last-wins, 1 neutral, 2 first-wins, 3 passthrough
//   restrict4  1 = 4-way (one axis only), 0 = 8-way
//   indir      raw directions, player p at [4p+3:4p], {U,D,L,R}, async to clk
//   outdir     conditioned directions, same packing as indir
//   change     one-cycle strobe per player, one cycle after its outdir changes

module joy_nway #(
    parameter int unsigned PLAYERS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             socd_mode,
    input  logic                   restrict4,
    input  logic [4*PLAYERS-1:0]   indir,
    output logic [4*PLAYERS-1:0]   outdir,
    output logic [PLAYERS-1:0]     change
);

    localparam logic [1:0] SOCD_LAST    = 2'd0;
    localparam logic [1:0] SOCD_NEUTRAL = 2'd1;
    localparam logic [1:0] SOCD_FIRST   = 2'd2;
    localparam logic [1:0] SOCD_PASS    = 2'd3;

    // Resolve one axis. held/last are {neg,pos} pairs ({L,R} or {U,D}).
    // last is one-hot once both are held, so its inverse is the earlier press.
    function automatic logic [1:0] socd_axis(input logic [1:0] held,
                                             input logic [1:0] last,
                                             input logic [1:0] mode);
        logic [1:0] res;
        res = held;
        if (held == 2'b11) begin
            case (mode)
                SOCD_LAST:    res = last;
                SOCD_NEUTRAL: res = 2'b00;
                SOCD_FIRST:   res = ~last;
                SOCD_PASS:    res = 2'b11;
                default:      res = 2'b00;
            endcase
        end
        return res;
    endfunction

    for (genvar p = 0; p < PLAYERS; p++) begin : g_ch
        logic [3:0] in1_q;
        logic [3:0] in2_q;
        logic [3:0] innew;
        logic [1:0] last_h_q;
        logic [1:0] last_h_d;
        logic [1:0] last_v_q;
        logic [1:0] last_v_d;
        logic       last_ax_q;
        logic       last_ax_d;
        logic [1:0] h_res;
        logic [1:0] v_res;
        logic [3:0] out_d;
        logic [3:0] out_q;
        logic [3:0] out_prev_q;
        logic       change_q;

        always_comb begin
            innew = in1_q & ~in2_q;

            // Look-ahead values: include this cycle's new presses so a
            // simultaneous press resolves immediately instead of going neutral.
            last_h_d = last_h_q;
            if (innew[1]) begin
                last_h_d = 2'b10;
            end else if (innew[0]) begin
                last_h_d = 2'b01;
            end

            last_v_d = last_v_q;
            if (innew[3]) begin
                last_v_d = 2'b10;
            end else if (innew[2]) begin
                last_v_d = 2'b01;
            end

            last_ax_d = last_ax_q;
            if (innew[3] || innew[2]) begin
                last_ax_d = 1'b1;
            end else if (innew[1] || innew[0]) begin
                last_ax_d = 1'b0;
            end

            h_res = socd_axis(in1_q[1:0], last_h_d, socd_mode);
            v_res = socd_axis(in1_q[3:2], last_v_d, socd_mode);

            out_d = {v_res, h_res};
            if (restrict4 && (h_res != 2'b00) && (v_res != 2'b00)) begin
                if (last_ax_d) begin
                    out_d = {v_res, 2'b00};
                end else begin
                    out_d = {2'b00, h_res};
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                in1_q      <= 4'b0000;
                in2_q      <= 4'b0000;
                last_h_q   <= 2'b00;
                last_v_q   <= 2'b00;
                last_ax_q  <= 1'b0;
                out_q      <= 4'b0000;
                out_prev_q <= 4'b0000;
                change_q   <= 1'b0;
            end else begin
                in1_q      <= indir[4*p +: 4];
                in2_q      <= in1_q;
                last_h_q   <= last_h_d;
                last_v_q   <= last_v_d;
                last_ax_q  <= last_ax_d;
                out_q      <= out_d;
                out_prev_q <= out_q;
                change_q   <= (out_q != out_prev_q);
            end
        end

        assign outdir[4*p +: 4] = out_q;
        assign change[p]        = change_q;
    end

endmodule

// File: tb/tb_joy_nway.sv
// tb_joy_nway: scoreboard bench for joy_nway with four players.
//
// Each table row gives indir for all players and the outdir the row must
// produce. Rows are pushed to the scoreboard as they are driven and popped
// when the registered output for that row appears. The expected change
// strobes are derived from the sequence of expected outdir values.

module tb_joy_nway;

    localparam int unsigned PLAYERS = 4;
    localparam int unsigned W       = 4 * PLAYERS;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         socd_mode;
    logic               restrict4;
    logic [W-1:0]       indir;
    logic [W-1:0]       outdir;
    logic [PLAYERS-1:0] change;

    joy_nway #(
        .PLAYERS (PLAYERS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .socd_mode (socd_mode),
        .restrict4 (restrict4),
        .indir     (indir),
        .outdir    (outdir),
        .change    (change)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] sb_q[$];
    logic [W-1:0] row_in[$];
    logic [W-1:0] row_exp[$];
    logic [1:0]   row_mode[$];
    logic         row_r4[$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_chk++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic add_seg(input int n, input logic [W-1:0] in_v, input logic [W-1:0] exp_v,
                           input logic [1:0] mode, input logic r4);
        for (int k = 0; k < n; k++) begin
            row_in.push_back(in_v);
            row_exp.push_back(exp_v);
            row_mode.push_back(mode);
            row_r4.push_back(r4);
        end
    endtask

    function automatic logic [PLAYERS-1:0] chg_of(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [PLAYERS-1:0] c;
        for (int p = 0; p < PLAYERS; p++) begin
            c[p] = (a[4*p +: 4] != b[4*p +: 4]);
        end
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] p1;
        logic [W-1:0] p2;
        int           nrows;

        // Nibbles are {p3,p2,p1,p0}.
        //      rows  indir     outdir    mode r4
        add_seg(3, 16'h0041, 16'h0041, 2'd0, 1'b0);
        add_seg(2, 16'h0841, 16'h0841, 2'd0, 1'b0);
        add_seg(4, 16'h0843, 16'h0842, 2'd0, 1'b0);  // R then L: last-wins -> L
        add_seg(2, 16'h0041, 16'h0041, 2'd0, 1'b0);  // release L -> R
        add_seg(1, 16'h0081, 16'h0081, 2'd0, 1'b0);
        add_seg(1, 16'h0080, 16'h0080, 2'd0, 1'b0);
        add_seg(2, 16'h0081, 16'h0081, 2'd0, 1'b0);
        add_seg(2, 16'h0283, 16'h0282, 2'd0, 1'b0);
        add_seg(2, 16'h0283, 16'h0280, 2'd1, 1'b0);  // neutral
        add_seg(1, 16'h0283, 16'h0281, 2'd2, 1'b0);  // first-wins -> R
        add_seg(1, 16'hC283, 16'h4281, 2'd2, 1'b0);  // p3 U+D tie, first-wins -> D
        add_seg(2, 16'hC253, 16'hC253, 2'd3, 1'b0);  // passthrough
        add_seg(1, 16'hC253, 16'h8252, 2'd0, 1'b0);
        add_seg(1, 16'hC250, 16'h8250, 2'd0, 1'b0);
        add_seg(3, 16'hC253, 16'h8252, 2'd0, 1'b0);  // simultaneous L+R -> L
        add_seg(1, 16'hC250, 16'h8250, 2'd0, 1'b0);
        add_seg(3, 16'hC25C, 16'h8258, 2'd0, 1'b0);  // simultaneous U+D -> U
        add_seg(1, 16'hC250, 16'h8250, 2'd0, 1'b0);
        add_seg(3, 16'hC251, 16'h8241, 2'd0, 1'b1);  // 4-way: p1 diagonal keeps D
        add_seg(3, 16'hC259, 16'h8248, 2'd0, 1'b1);  // add U -> vertical only
        add_seg(3, 16'hC25B, 16'h8242, 2'd0, 1'b1);  // add L -> horizontal, L
        add_seg(1, 16'hC250, 16'h8250, 2'd0, 1'b0);
        nrows = row_in.size();

        reset     = 1'b1;
        indir     = 16'hFFFF;
        socd_mode = 2'd0;
        restrict4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outdir", outdir, '0);
        check("reset_change", W'(change), '0);
        indir = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        p1 = '0;
        p2 = '0;
        // Control inputs reach outdir one edge sooner than indir, so they are
        // driven one step behind their row to line up with it.
        for (int i = 0; i <= nrows; i++) begin
            if (i < nrows) begin
                indir = row_in[i];
                sb_q.push_back(row_exp[i]);
            end
            socd_mode = row_mode[(i > 0) ? i - 1 : 0];
            restrict4 = row_r4[(i > 0) ? i - 1 : 0];
            @(posedge clk);
            #1;
            if (i > 0) begin
                exp_v = sb_q.pop_front();
                check($sformatf("row%0d_outdir", i - 1), outdir, exp_v);
                check($sformatf("row%0d_change", i - 1), W'(change), W'(chg_of(p1, p2)));
                p2 = p1;
                p1 = exp_v;
            end
        end

        // Reset mid-operation while a change strobe is high.
        indir = 16'h1483;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_reset_outdir", outdir, 16'h1482);
        @(posedge clk);
        #1;
        check("pre_reset_change", W'(change), W'(4'hF));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outdir", outdir, '0);
        check("async_reset_change", W'(change), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Held directions after release count as new presses; tie -> L.
        @(posedge clk);
        #1;
        check("release_e1_outdir", outdir, '0);
        check("release_e1_change", W'(change), '0);
        @(posedge clk);
        #1;
        check("release_e2_outdir", outdir, 16'h1482);
        check("release_e2_change", W'(change), '0);
        @(posedge clk);
        #1;
        check("release_e3_outdir", outdir, 16'h1482);
        check("release_e3_change", W'(change), W'(4'hF));
        @(posedge clk);
        #1;
        check("release_e4_change", W'(change), '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
